// File: rtl/soc_periph_pkg.sv
// Shared definitions for the soc_periph bus responder: register offsets,
// FSM state encoding and the byte-lane write helper.
package soc_periph_pkg;

    localparam logic [3:0] OFF_FLAG    = 4'h0;
    localparam logic [3:0] OFF_RESULT  = 4'h4;
    localparam logic [3:0] OFF_CYCLE   = 4'h8;
    localparam logic [3:0] OFF_SCRATCH = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } periph_state_e;

    function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int unsigned k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_periph.sv
// Memory-mapped test-result responder (FLAG, RESULT, CYCLE, SCRATCH) on a req/gnt/rvalid port.
// Define SOC_PERIPH_CYCLE_CNT_EN to build the free-running CYCLE counter at offset 0x8.
module soc_periph
    import soc_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] mem_flag_o,
    output logic [31:0] mem_result_o,
    output logic        done_o
);

    localparam logic [1:0] W_FLAG    = OFF_FLAG[3:2];
    localparam logic [1:0] W_RESULT  = OFF_RESULT[3:2];
    localparam logic [1:0] W_CYCLE   = OFF_CYCLE[3:2];
    localparam logic [1:0] W_SCRATCH = OFF_SCRATCH[3:2];
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    periph_state_e state_q, state_d;
    logic [3:0]    wait_q, wait_d;

    logic [31:0] flag_q, result_q, scratch_q;
    logic [31:0] rdata_q;
    logic        rvalid_q, err_q, done_q;

    logic        addr_hit;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        wr_flag, wr_result, wr_scratch;
    logic        unused_addr_lsb;

    assign addr_hit        = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign unused_addr_lsb = ^addr_i[1:0];

`ifdef SOC_PERIPH_CYCLE_CNT_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cycle_q <= '0;
        else         cycle_q <= cycle_q + 32'd1;
    end
`endif

    // RESP behaves like IDLE for a new request, which is what allows back-to-back grants.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        gnt_o   = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        gnt_o   = 1'b1;
                        state_d = RESP;
                    end else begin
                        wait_d  = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (wait_q == 4'd0) begin
                    gnt_o   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        resp_data = '0;
        resp_err  = 1'b0;
        if (!addr_hit) begin
            resp_err = 1'b1;
        end else begin
            case (addr_i[3:2])
                W_FLAG:    resp_data = flag_q;
                W_RESULT:  resp_data = result_q;
                W_SCRATCH: resp_data = scratch_q;
                W_CYCLE: begin
`ifdef SOC_PERIPH_CYCLE_CNT_EN
                    resp_data = cycle_q;
                    resp_err  = we_i;
`else
                    resp_err  = 1'b1;
`endif
                end
                default: resp_err = 1'b1;
            endcase
        end
        if (we_i) resp_data = '0;
    end

    assign wr_flag    = gnt_o & we_i & addr_hit & (addr_i[3:2] == W_FLAG);
    assign wr_result  = gnt_o & we_i & addr_hit & (addr_i[3:2] == W_RESULT);
    assign wr_scratch = gnt_o & we_i & addr_hit & (addr_i[3:2] == W_SCRATCH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q    <= '0;
            result_q  <= '0;
            scratch_q <= '0;
        end else begin
            if (wr_flag)    flag_q    <= apply_be(flag_q, wdata_i, be_i);
            if (wr_result)  result_q  <= apply_be(result_q, wdata_i, be_i);
            if (wr_scratch) scratch_q <= apply_be(scratch_q, wdata_i, be_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rvalid_q <= gnt_o;
            done_q   <= (flag_q != '0);
            if (gnt_o) begin
                rdata_q <= resp_data;
                err_q   <= resp_err;
            end
        end
    end

    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;
    assign done_o       = done_q;
    assign mem_flag_o   = flag_q;
    assign mem_result_o = result_q;

endmodule
